matmul_seq_engine: RTL and testbench

Sequential matrix-multiply datapath that sits directly downstream of the accelerator's Wishbone register/buffer front end.
- Once the controller raises start, it reads operand matrices A (M×K) and B (K×N) element-by-element from the front end's A/B buffers through synchronous read ports.
- It writes each C(i,j) result into the C buffer through a write port, then signals done.
- One MAC per cycle; no internal matrix storage.

---
 rtl/matmul_pkg.sv | 39 +++
 rtl/matmul_mac_unit.sv | 44 ++++
 rtl/matmul_seq_engine.sv | 197 +++++++++++++++++++
 tb/tb_matmul_seq_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types, default widths and the result saturation helper for the
// sequential matrix-multiply engine.
package matmul_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W  = 4;
  localparam int DEF_ACC_W  = 2 * DEF_DATA_W + DEF_IDX_W + 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic                  clamp;
  } sat_res_t;

  // The value fits in DATA_W only when every bit above the DATA_W sign bit
  // equals that sign bit; otherwise clamp towards the accumulator's sign.
  function automatic sat_res_t sat_to_data(input logic [DEF_ACC_W-1:0] acc);
    sat_res_t                        res;
    logic [DEF_ACC_W-DEF_DATA_W:0]   top_bits;
    top_bits  = acc[DEF_ACC_W-1:DEF_DATA_W-1];
    res.data  = acc[DEF_DATA_W-1:0];
    res.clamp = 1'b0;
    if (!((&top_bits) || !(|top_bits))) begin
      res.clamp = 1'b1;
      res.data  = acc[DEF_ACC_W-1] ? {1'b1, {(DEF_DATA_W-1){1'b0}}}
                                   : {1'b0, {(DEF_DATA_W-1){1'b1}}};
    end
    return res;
  endfunction

endpackage

// File: rtl/matmul_mac_unit.sv
// Registered signed multiply-accumulate: clear has priority over enable, and
// the full-precision product is sign-extended into the accumulator.
module matmul_mac_unit
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  logic signed [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]           prod_ext;
  logic [ACC_W-1:0]           acc_d;
  logic [ACC_W-1:0]           acc_q;

  always_comb begin
    prod     = $signed(a) * $signed(b);
    prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_d    = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/matmul_seq_engine.sv
// Sequential C = A x B engine: one MAC per cycle over external A/B read ports,
// each saturated C element written through the C port in row-major order.
module matmul_seq_engine
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = DEF_IDX_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [IDX_W-1:0]  dim_m,
  input  logic [IDX_W-1:0]  dim_k,
  input  logic [IDX_W-1:0]  dim_n,
  output logic              a_rd_en,
  output logic [IDX_W-1:0]  a_rd_row,
  output logic [IDX_W-1:0]  a_rd_col,
  input  logic [DATA_W-1:0] a_rd_data,
  output logic              b_rd_en,
  output logic [IDX_W-1:0]  b_rd_row,
  output logic [IDX_W-1:0]  b_rd_col,
  input  logic [DATA_W-1:0] b_rd_data,
  output logic              c_wr_en,
  output logic [IDX_W-1:0]  c_wr_row,
  output logic [IDX_W-1:0]  c_wr_col,
  output logic [DATA_W-1:0] c_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sat,
  output state_e            dbg_state
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
  logic [IDX_W-1:0] dm_q, dm_d, dk_q, dk_d, dn_q, dn_d;
  logic             sat_q, sat_d;
  logic             rd_issued_q, rd_issued_d;
  logic             start_ok, dims_zero, last_k, last_elem, mac_clr;
  logic [ACC_W-1:0] acc;
  sat_res_t         sat_res;

  assign start_ok  = (state_q == IDLE) && start;
  assign dims_zero = (dim_m == '0) || (dim_k == '0) || (dim_n == '0);
  assign last_k    = (k_q == dk_q - 1'b1);
  assign last_elem = (i_q == dm_q - 1'b1) && (j_q == dn_q - 1'b1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = dims_zero ? ERR : READ;
      READ:    if (last_k) state_d = DRAIN;
      DRAIN:   state_d = WRITE;
      WRITE:   state_d = last_elem ? DONE : READ;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dimension latches, loop counters and the sticky saturation flag.
  always_comb begin
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    dm_d        = dm_q;
    dk_d        = dk_q;
    dn_d        = dn_q;
    sat_d       = sat_q;
    rd_issued_d = (state_q == READ);
    if (start_ok) begin
      dm_d  = dim_m;
      dk_d  = dim_k;
      dn_d  = dim_n;
      sat_d = 1'b0;
      i_d   = '0;
      j_d   = '0;
      k_d   = '0;
    end
    if (state_q == READ) begin
      k_d = k_q + 1'b1;
    end
    if (state_q == WRITE) begin
      sat_d = sat_q | sat_res.clamp;
      k_d   = '0;
      if (j_q != dn_q - 1'b1) begin
        j_d = j_q + 1'b1;
      end else begin
        j_d = '0;
        if (i_q != dm_q - 1'b1) begin
          i_d = i_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      dm_q        <= '0;
      dk_q        <= '0;
      dn_q        <= '0;
      sat_q       <= 1'b0;
      rd_issued_q <= 1'b0;
    end else begin
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      dm_q        <= dm_d;
      dk_q        <= dk_d;
      dn_q        <= dn_d;
      sat_q       <= sat_d;
      rd_issued_q <= rd_issued_d;
    end
  end

  // Read data returns one cycle after the strobe, so accumulation follows
  // the registered copy of "a read was issued last cycle".
  assign mac_clr = start_ok || (state_q == WRITE);

  matmul_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk   (clk),
    .reset (reset),
    .clr   (mac_clr),
    .en    (rd_issued_q),
    .a     (a_rd_data),
    .b     (b_rd_data),
    .acc   (acc)
  );

  always_comb begin
    sat_res = sat_to_data(acc);
  end

  always_comb begin
    a_rd_en   = 1'b0;
    a_rd_row  = '0;
    a_rd_col  = '0;
    b_rd_en   = 1'b0;
    b_rd_row  = '0;
    b_rd_col  = '0;
    c_wr_en   = 1'b0;
    c_wr_row  = '0;
    c_wr_col  = '0;
    c_wr_data = '0;
    busy      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      READ: begin
        busy     = 1'b1;
        a_rd_en  = 1'b1;
        a_rd_row = i_q;
        a_rd_col = k_q;
        b_rd_en  = 1'b1;
        b_rd_row = k_q;
        b_rd_col = j_q;
      end
      DRAIN: busy = 1'b1;
      WRITE: begin
        busy      = 1'b1;
        c_wr_en   = 1'b1;
        c_wr_row  = i_q;
        c_wr_col  = j_q;
        c_wr_data = sat_res.data;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      ERR: begin
        busy = 1'b1;
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign sat       = sat_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_matmul_seq_engine.sv
// Directed bench for matmul_seq_engine: table of matrix runs with hand-computed
// results, plus mid-run reset and start-while-busy sequences.
module tb_matmul_seq_engine;
  import matmul_pkg::*;

  localparam int NV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  dim_m = '0, dim_k = '0, dim_n = '0;
  logic        a_rd_en, b_rd_en, c_wr_en;
  logic [3:0]  a_rd_row, a_rd_col, b_rd_row, b_rd_col, c_wr_row, c_wr_col;
  logic [31:0] a_rd_data = '0, b_rd_data = '0, c_wr_data;
  logic        busy, done, err, sat;
  state_e      dbg_state;

  logic [31:0] a_mem [16][16];
  logic [31:0] b_mem [16][16];
  logic [39:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          m, k, n;
    logic [31:0] a [16];
    logic [31:0] b [16];
    logic [31:0] c [16];
    int          done_cyc;
    bit          err;
    bit          sat;
  } vec_t;

  vec_t vecs [NV];

  matmul_seq_engine dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dim_m     (dim_m),
    .dim_k     (dim_k),
    .dim_n     (dim_n),
    .a_rd_en   (a_rd_en),
    .a_rd_row  (a_rd_row),
    .a_rd_col  (a_rd_col),
    .a_rd_data (a_rd_data),
    .b_rd_en   (b_rd_en),
    .b_rd_row  (b_rd_row),
    .b_rd_col  (b_rd_col),
    .b_rd_data (b_rd_data),
    .c_wr_en   (c_wr_en),
    .c_wr_row  (c_wr_row),
    .c_wr_col  (c_wr_col),
    .c_wr_data (c_wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sat       (sat),
    .dbg_state (dbg_state)
  );

  // Clock / reset and the A/B buffer model (synchronous read, 1-cycle latency)
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_row][a_rd_col];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_row][b_rd_col];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] all_outputs();
    return {33'd0, a_rd_en, b_rd_en, c_wr_en, busy, done, err, sat,
            a_rd_row, a_rd_col, b_rd_row, b_rd_col, c_wr_row, c_wr_col} | {32'd0, c_wr_data};
  endfunction

  task automatic set_hdr(input int idx, input int m, input int k, input int n,
                         input int dc, input bit e, input bit s);
    vecs[idx].m        = m;
    vecs[idx].k        = k;
    vecs[idx].n        = n;
    vecs[idx].done_cyc = dc;
    vecs[idx].err      = e;
    vecs[idx].sat      = s;
    vecs[idx].a        = '{default: 32'd0};
    vecs[idx].b        = '{default: 32'd0};
    vecs[idx].c        = '{default: 32'd0};
  endtask

  task automatic load_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        a_mem[r][c] = 32'h0BAD_0000 | 32'(r * 16 + c);
        b_mem[r][c] = 32'h0EEE_0000 | 32'(r * 16 + c);
      end
    end
    for (int r = 0; r < v.m; r++)
      for (int c = 0; c < v.k; c++) a_mem[r][c] = v.a[r * v.k + c];
    for (int r = 0; r < v.k; r++)
      for (int c = 0; c < v.n; c++) b_mem[r][c] = v.b[r * v.n + c];
  endtask

  // Driver: one run from start to done, with a scoreboard of expected writes.
  task automatic run_vec(input int idx, input bit poke_start);
    vec_t        v;
    int          cyc, wr, n_exp;
    bit          seen_done, busy_ok, strobe_bad;
    logic [39:0] got, exp;
    v = vecs[idx];
    load_vec(idx);
    exp_q.delete();
    n_exp = v.err ? 0 : v.m * v.n;
    for (int e = 0; e < n_exp; e++)
      exp_q.push_back({4'(e / v.n), 4'(e % v.n), v.c[e]});
    @(posedge clk); #1;
    dim_m = 4'(v.m);
    dim_k = 4'(v.k);
    dim_n = 4'(v.n);
    start = 1'b1;
    cyc = 0; wr = 0; seen_done = 0; busy_ok = 1; strobe_bad = 0;
    while (!seen_done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start = poke_start && (cyc == 5);
      if (cyc == 1) begin
        dim_m = 4'($urandom_range(0, 15));
        dim_k = 4'($urandom_range(0, 15));
        dim_n = 4'($urandom_range(0, 15));
      end
      if (!busy) busy_ok = 0;
      if (v.err && (a_rd_en || b_rd_en || c_wr_en)) strobe_bad = 1;
      if (c_wr_en) begin
        wr++;
        got = {c_wr_row, c_wr_col, c_wr_data};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL c_wr_extra vec=%0d actual=%0h expected=none", idx, got);
        end else begin
          exp = exp_q.pop_front();
          check($sformatf("c_wr vec=%0d", idx), 64'(got), 64'(exp));
        end
      end
      if (done) begin
        seen_done = 1;
        check($sformatf("done_cyc vec=%0d", idx), 64'(cyc), 64'(v.done_cyc));
        check($sformatf("err vec=%0d", idx), 64'(err), 64'(v.err));
        check($sformatf("sat vec=%0d", idx), 64'(sat), 64'(v.sat));
      end
    end
    start = 1'b0;
    if (!seen_done) begin
      checks++;
      errors++;
      $display("FAIL timeout vec=%0d actual=no_done expected=done", idx);
    end
    check($sformatf("wr_count vec=%0d", idx), 64'(wr), 64'(n_exp));
    check($sformatf("busy_held vec=%0d", idx), 64'(busy_ok), 64'd1);
    check($sformatf("err_strobes vec=%0d", idx), 64'(strobe_bad), 64'd0);
    @(posedge clk); #1;
    check($sformatf("idle_after vec=%0d", idx), {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    // M=K=N=1, 3 * -4
    set_hdr(0, 1, 1, 1, 4, 0, 0);
    vecs[0].a[0] = 32'd3;
    vecs[0].b[0] = -32'sd4;
    vecs[0].c[0] = 32'hFFFF_FFF4;
    // 2x2 identity times [[1,2],[3,4]]
    set_hdr(1, 2, 2, 2, 17, 0, 0);
    vecs[1].a = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].b = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].c = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // 3x4 times 4x2, mixed signs
    set_hdr(2, 3, 4, 2, 37, 0, 0);
    vecs[2].a = '{1, 2, 3, 4, -1, 0, 5, -2, 7, -3, 2, 1, 0, 0, 0, 0};
    vecs[2].b = '{2, -1, 0, 3, 1, 1, -2, 4, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].c = '{-3, 24, 7, -2, 14, -10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // positive saturation, then sat cleared by a small run
    set_hdr(3, 1, 1, 1, 4, 0, 1);
    vecs[3].a[0] = 32'h7FFF_FFFF;
    vecs[3].b[0] = 32'd2;
    vecs[3].c[0] = 32'h7FFF_FFFF;
    set_hdr(4, 1, 1, 1, 4, 0, 0);
    vecs[4].a[0] = 32'd5;
    vecs[4].b[0] = 32'd6;
    vecs[4].c[0] = 32'd30;
    // negative saturation: -2^31 * 2
    set_hdr(5, 1, 1, 1, 4, 0, 1);
    vecs[5].a[0] = 32'h8000_0000;
    vecs[5].b[0] = 32'd2;
    vecs[5].c[0] = 32'h8000_0000;
    // intermediate sum exceeds 32 bits but the result is zero
    set_hdr(6, 1, 2, 1, 5, 0, 0);
    vecs[6].a[0] = 32'h7FFF_FFFF;
    vecs[6].a[1] = 32'h7FFF_FFFF;
    vecs[6].b[0] = 32'd2;
    vecs[6].b[1] = -32'sd2;
    vecs[6].c[0] = 32'd0;
    // zero dimensions
    set_hdr(7, 2, 0, 2, 1, 1, 0);
    set_hdr(8, 0, 3, 3, 1, 1, 0);
    // maximum inner dimension
    set_hdr(9, 1, 15, 1, 18, 0, 0);
    vecs[9].a = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    vecs[9].b = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    vecs[9].c[0] = 32'd15;

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outputs(), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(IDLE));
    reset = 1'b0;

    for (int v = 0; v < NV; v++) run_vec(v, 1'b0);

    // Reset asserted in the middle of the 2x2x2 run
    load_vec(1);
    @(posedge clk); #1;
    dim_m = 4'd2; dim_k = 4'd2; dim_n = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_read_state", 64'(dbg_state), 64'(READ));
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", all_outputs(), 64'd0);
    check("async_reset_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(1, 1'b0);

    // Start pulsed while busy must not disturb the run
    run_vec(2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
